// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results win the single write port, LSU results wait in a FIFO.
// Optional macro WB_HAZARD_EN adds a combinational stall check against pending FIFO destinations.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  input  logic [4:0]               chk_rs1,
  input  logic [4:0]               chk_rs2,
  input  logic [4:0]               chk_rd,
  output logic                     hazard,
  output logic                     WE,
  output logic [4:0]               rsw,
  output logic [31:0]              dataW,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [4:0]    r_rsw;
  logic [31:0]   r_data;

  logic w_alu_eff;
  logic w_ready;
  logic w_pop;
  logic w_push;

  // rd=0 results are architecturally dead, so they neither write nor occupy the port.
  assign w_alu_eff = alu_valid & (alu_rd != 5'd0);
  assign w_ready   = ~rst & (r_cnt < FULL);
  assign w_pop     = ~w_alu_eff & (r_cnt != '0);
  assign w_push    = lsu_valid & w_ready & (lsu_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_rsw    <= '0;
      r_data   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_alu_eff) begin
        r_we   <= 1'b1;
        r_rsw  <= alu_rd;
        r_data <= alu_data;
      end else if (w_pop) begin
        r_we   <= 1'b1;
        r_rsw  <= r_mem_rd[r_rd_ptr];
        r_data <= r_mem_data[r_rd_ptr];
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= lsu_rd;
      r_mem_data[r_wr_ptr] <= lsu_data;
    end
  end

`ifdef WB_HAZARD_EN
  logic w_hazard;

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(AW'(i) - r_rd_ptr) < r_cnt) &&
          (((r_mem_rd[i] == chk_rs1) && (chk_rs1 != 5'd0)) ||
           ((r_mem_rd[i] == chk_rs2) && (chk_rs2 != 5'd0)) ||
           ((r_mem_rd[i] == chk_rd)  && (chk_rd  != 5'd0))))
        w_hazard = 1'b1;
    end
  end

  assign hazard = w_hazard;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{chk_rs1, chk_rs2, chk_rd};
  assign hazard       = 1'b0;
`endif

  assign lsu_ready = w_ready;
  assign WE        = r_we;
  assign rsw       = r_rsw;
  assign dataW     = r_data;
  assign pend_cnt  = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences for hazard/reset, then random traffic
// checked against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
`ifdef WB_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, lsu_valid, lsu_ready, hazard, WE;
  logic [4:0]  alu_rd, lsu_rd, chk_rs1, chk_rs2, chk_rd, rsw;
  logic [31:0] alu_data, lsu_data, dataW;
  logic [$clog2(DEPTH):0] pend_cnt;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .WE(WE), .rsw(rsw), .dataW(dataW), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        rdy;
    logic        we;
    logic [4:0]  rsw;
    logic [31:0] dat;
    int          cnt;
  } vec_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_rsw;
  logic [31:0] m_data;
  logic        s_rdy, s_hz;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_rsw = '0; m_data = '0;
  endtask

  // Called just after a rising edge; applies one cycle of inputs and checks both sides of the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cd);
    ent_t e;
    bit   rdy, hz;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    chk_rs1 = c1; chk_rs2 = c2; chk_rd = cd;
    #1;
    rdy = (q.size() < DEPTH);
    hz  = 1'b0;
    if (HZ_EN)
      foreach (q[k])
        if ((c1 != 0 && q[k].rd == c1) || (c2 != 0 && q[k].rd == c2) || (cd != 0 && q[k].rd == cd))
          hz = 1'b1;
    s_rdy = lsu_ready;
    s_hz  = hazard;
    chk("lsu_ready", lsu_ready, rdy);
    chk("hazard", hazard, hz);
    chk("pend_cnt_pre", pend_cnt, q.size());
    if (av && ard != 0) begin
      m_we = 1'b1; m_rsw = ard; m_data = adat;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rsw = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (lv && rdy && lrd != 0) begin
      e.rd = lrd; e.data = ldat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("WE", WE, m_we);
    chk("rsw", rsw, m_rsw);
    chk("dataW", dataW, m_data);
    chk("pend_cnt", pend_cnt, q.size());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 3, 9966,     0, 0, 0,     1, 1, 3,  9966,     0};
    tbl[1]  = '{0, 0, 0,        0, 0, 0,     1, 0, 3,  9966,     0};
    tbl[2]  = '{1, 1, 100,      1, 5, 'hAA,  1, 1, 1,  100,      1};
    tbl[3]  = '{1, 2, 200,      0, 0, 0,     1, 1, 2,  200,      1};
    tbl[4]  = '{1, 3, 300,      0, 0, 0,     1, 1, 3,  300,      1};
    tbl[5]  = '{0, 0, 0,        0, 0, 0,     1, 1, 5,  'hAA,     0};
    tbl[6]  = '{1, 0, 77,       1, 0, 'h55,  1, 0, 5,  'hAA,     0};
    tbl[7]  = '{0, 0, 0,        0, 0, 0,     1, 0, 5,  'hAA,     0};
    tbl[8]  = '{1, 10, 'h1000,  1, 1, 'h11,  1, 1, 10, 'h1000,   1};
    tbl[9]  = '{1, 11, 'h1001,  1, 2, 'h22,  1, 1, 11, 'h1001,   2};
    tbl[10] = '{1, 12, 'h1002,  1, 3, 'h33,  1, 1, 12, 'h1002,   3};
    tbl[11] = '{1, 13, 'h1003,  1, 4, 'h44,  1, 1, 13, 'h1003,   4};
    tbl[12] = '{1, 14, 'h1004,  1, 9, 'h99,  0, 1, 14, 'h1004,   4};
    tbl[13] = '{0, 0, 0,        1, 9, 'h99,  0, 1, 1,  'h11,     3};
    tbl[14] = '{0, 0, 0,        0, 0, 0,     1, 1, 2,  'h22,     2};
    tbl[15] = '{0, 0, 0,        0, 0, 0,     1, 1, 3,  'h33,     1};
    tbl[16] = '{0, 0, 0,        0, 0, 0,     1, 1, 4,  'h44,     0};
    tbl[17] = '{0, 0, 0,        0, 0, 0,     1, 0, 4,  'h44,     0};
    tbl[18] = '{0, 0, 0,        1, 6, 'h66,  1, 0, 4,  'h44,     1};
    tbl[19] = '{0, 0, 0,        1, 7, 'h77,  1, 1, 6,  'h66,     1};
    tbl[20] = '{0, 0, 0,        0, 0, 0,     1, 1, 7,  'h77,     0};

    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    model_reset();
    #1;
    chk("rst_WE", WE, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", lsu_ready, 1);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat, 0, 0, 0);
      chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), WE, tbl[i].we);
      chk($sformatf("tbl%0d_rsw", i), rsw, tbl[i].rsw);
      chk($sformatf("tbl%0d_data", i), dataW, tbl[i].dat);
      chk($sformatf("tbl%0d_cnt", i), pend_cnt, tbl[i].cnt);
    end

    // Hazard against a pending destination, then cleared once drained.
    step(1, 1, 1, 1, 7, 'h70, 0, 7, 0);
    step(1, 2, 2, 0, 0, 0, 0, 7, 0);
    chk("hz_pending_rs2", s_hz, HZ_EN);
    step(1, 3, 3, 0, 0, 0, 0, 0, 0);
    chk("hz_zero_srcs", s_hz, 0);
    step(1, 4, 4, 0, 0, 0, 0, 0, 7);
    chk("hz_pending_rd", s_hz, HZ_EN);
    step(0, 0, 0, 0, 0, 0, 7, 0, 0);
    chk("hz_popping_rs1", s_hz, HZ_EN);
    chk("hz_drain_write", rsw, 7);
    step(0, 0, 0, 0, 0, 0, 7, 7, 7);
    chk("hz_after_drain", s_hz, 0);

    // Reset mid-drain with three entries still pending.
    for (int i = 1; i <= 4; i++) step(1, 5'(20 + i), i, 1, 5'(i), 32'h500 + i, 0, 0, 0);
    idle();
    chk("pre_rst_cnt", pend_cnt, 3);
    alu_valid = 0; lsu_valid = 1; lsu_rd = 9; lsu_data = 'h999;
    #2; rst = 1'b1; #1;
    chk("midrst_WE", WE, 0);
    chk("midrst_rsw", rsw, 0);
    chk("midrst_dataW", dataW, 0);
    chk("midrst_cnt", pend_cnt, 0);
    chk("midrst_ready", lsu_ready, 0);
    chk("midrst_hazard", hazard, 0);
    @(posedge clk); #1;
    chk("held_rst_cnt", pend_cnt, 0);
    chk("held_rst_WE", WE, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("release_ready", lsu_ready, 1);
    for (int i = 0; i < 4; i++) idle();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom(),
           $urandom_range(0, 99) < 55,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, LSU result FIFO entries; power of 2, range 2..16.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port alu_valid  in  1  ALU result present this cycle; never back-pressured.
REQ-005 SHALL have port alu_rd  in  5  ALU destination register.
REQ-006 SHALL have port alu_data  in  32  ALU result.
REQ-007 SHALL have port lsu_valid  in  1  load/long-latency result offered.
REQ-008 SHALL have port lsu_ready  out  1  FIFO can accept; transfer when lsu_valid & lsu_ready.
REQ-009 SHALL have port lsu_rd  in  5  LSU destination register.
REQ-010 SHALL have port lsu_data  in  32  LSU result.
REQ-011 SHALL have port chk_rs1  in  5  issuing instruction source 1, for hazard check.
REQ-012 SHALL have port chk_rs2  in  5  issuing instruction source 2.
REQ-013 SHALL have port chk_rd  in  5  issuing instruction destination.
REQ-014 SHALL have port hazard  out  1  issuing instruction must stall.
REQ-015 SHALL have port WE  out  1  register-file write enable, registered.
REQ-016 SHALL have port rsw  out  5  register-file write index, registered.
REQ-017 SHALL have port dataW  out  32  register-file write data, registered.
REQ-018 SHALL have port pend_cnt  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 SHALL update WE/rsw/dataW only on rising clk; exactly one register write per cycle maximum.
REQ-020 SHALL treat alu_valid with alu_rd=0 as alu_valid=0: no WE, slot free for FIFO drain.
REQ-021 SHALL, when effective alu_valid=1, drive WE=1, rsw=alu_rd, dataW=alu_data next cycle; ALU latency 1 cycle.
REQ-022 SHALL, when effective alu_valid=0 and pend_cnt>0, pop FIFO head and drive WE=1 with its rd/data next cycle.
REQ-023 SHALL drive WE=0 next cycle when neither source writes; rsw/dataW hold last value.
REQ-024 SHALL drive lsu_ready = (pend_cnt < DEPTH) from registered count only; a same-cycle pop does not raise ready.
REQ-025 SHALL push every LSU transfer with lsu_rd!=0 at the write pointer; transfers with lsu_rd=0 complete handshake and are discarded.
REQ-026 SHALL never bypass the FIFO; minimum LSU-to-WE latency 2 cycles.
REQ-027 SHALL preserve LSU order; pointers wrap modulo DEPTH; simultaneous push and pop leaves pend_cnt unchanged.
REQ-028 SHALL ignore lsu_valid while lsu_ready=0; no overwrite, no count change.

Reset
REQ-029 SHALL, on rst assertion at any time including mid-drain, immediately force WE=0, rsw=0, dataW=0, pend_cnt=0, pointers=0, lsu_ready=0, hazard=0; pending entries lost.
REQ-030 SHALL raise lsu_ready on the first cycle after rst deassertion.

Configuration
REQ-031 SHALL, with WB_HAZARD_EN defined, assert hazard combinationally when any valid FIFO entry rd equals nonzero chk_rs1, chk_rs2 or chk_rd.
REQ-032 SHALL, without WB_HAZARD_EN, tie hazard to 0; ordering is then the core's responsibility.

Verification
REQ-033 SHALL cover: alu_valid=1, alu_rd=3, alu_data=9966 -> next edge WE=1, rsw=3, dataW=9966; following idle cycle WE=0.
REQ-034 SHALL cover: LSU push rd=5 data=0xAA with alu_valid=1 for 3 cycles -> WE only for ALU, then rd=5 written on first ALU-idle cycle.
REQ-035 SHALL cover: 4 LSU pushes, ALU busy (DEPTH=4) -> pend_cnt=4, lsu_ready=0, 5th offer not accepted; drain order 1,2,3,4.
REQ-036 SHALL cover: alu_rd=0 or lsu_rd=0 -> no WE for that result, pend_cnt unchanged for LSU.
REQ-037 SHALL cover: WB_HAZARD_EN, pending rd=7, chk_rs2=7 -> hazard=1; after drain hazard=0; chk_rs1=0 never hazards.
REQ-038 SHALL cover: rst pulse with pend_cnt=3 mid-drain -> all outputs 0 immediately; no stale write after release.
